// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// supported opcode/funct3 pairs and the datapath control codes.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EX_I   = 3'd2,
      EX_B   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_LBU  = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// Classifies the held instruction into one of the supported classes
// (addi, bne, lbu) or flags it as illegal.
module main_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int INSTR_LEN = 32
) (
   input  logic [INSTR_LEN-1:0] instr,
   output logic                 cls_i,
   output logic                 cls_b,
   output logic                 cls_ld,
   output logic                 illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   // Register and immediate fields are consumed by the datapath, not here.
   assign unused_fields = ^{instr[INSTR_LEN-1:15], instr[11:7]};

   assign cls_i   = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
   assign cls_b   = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
   assign cls_ld  = (opcode == OP_LOAD)   && (funct3 == F3_LBU);
   assign illegal = !(cls_i || cls_b || cls_ld);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the reduced RISC-V datapath: fetch handshake,
// per-state datapath controls, ack timeout and retired-instruction count.
module multicycle_controller
   import rv_ctrl_pkg::*;
#(
   parameter int INSTR_LEN = 32,
   parameter int CNT_W     = 16,
   parameter int MAX_WAIT  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [INSTR_LEN-1:0] instr,
   input  logic                 EQ,
   input  logic                 imem_ack,
   input  logic                 dmem_ack,
   output logic                 imem_req,
   output logic                 IRwrite,
   output logic                 PCwrite,
   output logic                 PCsrc,
   output logic                 RegWrite,
   output logic                 ResultSrc,
   output logic [2:0]           ALUctrl,
   output logic                 ALUsrc,
   output logic [1:0]           ImmSrc,
   output logic                 dmem_req,
   output logic                 halt,
   output logic [1:0]           err_code,
   output logic [CNT_W-1:0]     instret
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_t            state, state_nx;
   logic [WAIT_W-1:0] wait_cnt, wait_nx;
   logic [1:0]        err_nx;
   logic              retire;
   logic              req, ack;
   logic              cls_i, cls_b, cls_ld, illegal;

   main_decoder #(.INSTR_LEN(INSTR_LEN)) u_dec (
      .instr   (instr),
      .cls_i   (cls_i),
      .cls_b   (cls_b),
      .cls_ld  (cls_ld),
      .illegal (illegal)
   );

   // The one outstanding handshake, if any, in the current state.
   assign req = ((state == FETCH) && en) || (state == MEM);
   assign ack = (state == FETCH) ? imem_ack : dmem_ack;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_nx = state;
      wait_nx  = '0;
      err_nx   = err_code;
      retire   = 1'b0;
      unique case (state)
         FETCH, MEM: begin
            if (req && ack) begin
               state_nx = (state == FETCH) ? DECODE : WB;
            end else if (req && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
               state_nx = HALT;
               err_nx   = ERR_TIMEOUT;
            end else if (req) begin
               wait_nx = wait_cnt + WAIT_W'(1);
            end
         end
         DECODE: begin
            if (cls_i)       state_nx = EX_I;
            else if (cls_b)  state_nx = EX_B;
            else if (cls_ld) state_nx = MEM;
            else begin
               state_nx = HALT;
               err_nx   = ERR_ILLEGAL;
            end
         end
         EX_I, EX_B, WB: begin
            state_nx = FETCH;
            retire   = 1'b1;
         end
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         wait_cnt <= '0;
         err_code <= ERR_NONE;
         instret  <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         err_code <= err_nx;
         if (retire) instret <= instret + CNT_W'(1);
      end
   end

   always_comb begin
      imem_req  = 1'b0;
      IRwrite   = 1'b0;
      PCwrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      ALUctrl   = ALU_ADD;
      ALUsrc    = 1'b0;
      ImmSrc    = IMM_I;
      dmem_req  = 1'b0;
      halt      = 1'b0;
      unique case (state)
         // FETCH is the reset state, so its en-driven strobes are masked while rst_n is low.
         FETCH: begin
            imem_req = en && rst_n;
            IRwrite  = en && imem_ack && rst_n;
         end
         EX_I: begin
            ALUsrc   = 1'b1;
            ImmSrc   = IMM_I;
            ALUctrl  = ALU_ADD;
            RegWrite = 1'b1;
            PCwrite  = 1'b1;
         end
         EX_B: begin
            ALUctrl = ALU_SUB;
            ImmSrc  = IMM_B;
            PCwrite = 1'b1;
            PCsrc   = ~EQ;
         end
         MEM: begin
            dmem_req = 1'b1;
            ALUsrc   = 1'b1;
            ImmSrc   = IMM_I;
            ALUctrl  = ALU_ADD;
         end
         WB: begin
            RegWrite  = 1'b1;
            ResultSrc = 1'b1;
            PCwrite   = 1'b1;
         end
         HALT:    halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench for multicycle_controller, with a second
// small instance (MAX_WAIT=3, CNT_W=2) for timeout and counter-wrap cases.
module tb_multicycle_controller;

   localparam int MW_A = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters
   logic        rst_n, en, eq, imem_ack, dmem_ack;
   logic [31:0] instr;
   logic        imem_req, IRwrite, PCwrite, PCsrc, RegWrite, ResultSrc, ALUsrc, dmem_req, halt;
   logic [2:0]  ALUctrl;
   logic [1:0]  ImmSrc, err_code;
   logic [15:0] instret;

   // Instance B: MAX_WAIT=3, CNT_W=2
   logic        b_rst_n, b_en, b_eq, b_imem_ack, b_dmem_ack;
   logic [31:0] b_instr;
   logic        b_imem_req, b_IRwrite, b_PCwrite, b_PCsrc, b_RegWrite, b_ResultSrc, b_ALUsrc;
   logic        b_dmem_req, b_halt;
   logic [2:0]  b_ALUctrl;
   logic [1:0]  b_ImmSrc, b_err_code;
   logic [1:0]  b_instret;

   multicycle_controller dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .instr(instr), .EQ(eq),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .IRwrite(IRwrite),
      .PCwrite(PCwrite), .PCsrc(PCsrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .dmem_req(dmem_req),
      .halt(halt), .err_code(err_code), .instret(instret)
   );

   multicycle_controller #(.INSTR_LEN(32), .CNT_W(2), .MAX_WAIT(3)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .en(b_en), .instr(b_instr), .EQ(b_eq),
      .imem_ack(b_imem_ack), .dmem_ack(b_dmem_ack), .imem_req(b_imem_req), .IRwrite(b_IRwrite),
      .PCwrite(b_PCwrite), .PCsrc(b_PCsrc), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc),
      .ALUctrl(b_ALUctrl), .ALUsrc(b_ALUsrc), .ImmSrc(b_ImmSrc), .dmem_req(b_dmem_req),
      .halt(b_halt), .err_code(b_err_code), .instret(b_instret)
   );

   logic [15:0] a_vec, b_vec;
   assign a_vec = {imem_req, IRwrite, PCwrite, PCsrc, RegWrite, ResultSrc, ALUctrl,
                   ALUsrc, ImmSrc, dmem_req, halt, err_code};
   assign b_vec = {b_imem_req, b_IRwrite, b_PCwrite, b_PCsrc, b_RegWrite, b_ResultSrc, b_ALUctrl,
                   b_ALUsrc, b_ImmSrc, b_dmem_req, b_halt, b_err_code};

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned model_ret;
   int unsigned b_ret;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control vector, fields in the same order as a_vec/b_vec.
   function automatic logic [15:0] vec(input logic ireq, input logic irw, input logic pcw,
                                       input logic pcs, input logic rw, input logic rs,
                                       input logic [2:0] alu, input logic asrc,
                                       input logic [1:0] imm, input logic dreq,
                                       input logic hlt, input logic [1:0] err);
      return {ireq, irw, pcw, pcs, rw, rs, alu, asrc, imm, dreq, hlt, err};
   endfunction

   // Instruction generator: 0 addi, 1 bne, 2 lbu, 3 unsupported encoding.
   function automatic logic [31:0] gen(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         0: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
         1: begin r[6:0] = 7'b1100011; r[14:12] = 3'b001; end
         2: begin r[6:0] = 7'b0000011; r[14:12] = 3'b100; end
         default: begin
            case ($urandom_range(0, 2))
               0: r = 32'h0000_0033;
               1: begin r[6:0] = 7'b0010011; r[14:12] = 3'b001; end
               default: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
            endcase
         end
      endcase
      return r;
   endfunction

   // One cycle on A: inputs already driven; sample on the falling edge.
   task automatic tick(input string tag, input logic [15:0] exp);
      @(negedge clk);
      check({tag, "_ctl"}, {16'h0, a_vec}, {16'h0, exp});
      check({tag, "_ret"}, {16'h0, instret}, model_ret & 32'hFFFF);
      @(posedge clk);
      #1;
   endtask

   task automatic b_tick(input string tag, input logic [15:0] exp);
      @(negedge clk);
      check({tag, "_ctl"}, {16'h0, b_vec}, {16'h0, exp});
      check({tag, "_ret"}, {30'h0, b_instret}, b_ret % 4);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      rst_n = 1'b0;
      en    = 1'b1;
      imem_ack = 1'b1;
      #2;
      model_ret = 0;
      check("reset_outputs", {16'h0, a_vec}, 32'h0);
      check("reset_instret", {16'h0, instret}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b0;
      imem_ack = 1'b0;
   endtask

   task automatic reset_b();
      b_rst_n = 1'b0;
      #2;
      b_ret = 0;
      @(posedge clk);
      #1;
      b_rst_n = 1'b1;
   endtask

   task automatic idle_a(input int n);
      en = 1'b0;
      for (int i = 0; i < n; i++) begin
         imem_ack = 1'($urandom);
         dmem_ack = 1'($urandom);
         tick("idle", 16'h0);
      end
   endtask

   // Run one instruction on A: iw fetch wait cycles, dw load wait cycles.
   task automatic run_instr(input int kind, input int iw, input int dw, input logic e);
      en = 1'b1;
      for (int i = 0; i <= iw; i++) begin
         imem_ack = (i == iw);
         dmem_ack = 1'($urandom);
         eq       = 1'($urandom);
         tick("fetch", vec(1, (i == iw), 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      end
      instr    = gen(kind);
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      en       = 1'($urandom);
      tick("decode", 16'h0);
      case (kind)
         0: begin
            tick("ex_i", vec(0, 0, 1, 0, 1, 0, 3'b000, 1, 2'b00, 0, 0, 2'b00));
            model_ret++;
         end
         1: begin
            eq = e;
            tick("ex_b", vec(0, 0, 1, ~e, 0, 0, 3'b001, 0, 2'b10, 0, 0, 2'b00));
            model_ret++;
         end
         2: begin
            for (int j = 0; j <= dw; j++) begin
               dmem_ack = (j == dw);
               imem_ack = 1'($urandom);
               tick("mem", vec(0, 0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 1, 0, 2'b00));
            end
            dmem_ack = 1'($urandom);
            tick("wb", vec(0, 0, 1, 0, 1, 1, 3'b000, 0, 2'b00, 0, 0, 2'b00));
            model_ret++;
         end
         default: begin
            for (int k = 0; k < 5; k++) begin
               en       = 1'($urandom);
               imem_ack = 1'($urandom);
               dmem_ack = 1'($urandom);
               tick("halt_illegal", vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 2'b01));
            end
            reset_a();
         end
      endcase
   endtask

   task automatic b_run_addi();
      b_en = 1'b1;
      b_imem_ack = 1'b1;
      b_tick("b_fetch", vec(1, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      b_instr = gen(0);
      b_imem_ack = 1'b0;
      b_tick("b_decode", 16'h0);
      b_tick("b_ex_i", vec(0, 0, 1, 0, 1, 0, 3'b000, 1, 2'b00, 0, 0, 2'b00));
      b_ret++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; eq = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0;
      b_rst_n = 1'b0; b_en = 1'b0; b_eq = 1'b0; b_imem_ack = 1'b0; b_dmem_ack = 1'b0; b_instr = '0;
      model_ret = 0;
      b_ret = 0;
      #3;
      reset_b();
      reset_a();

      // Back-to-back addi with zero-wait acks: 3 cycles each.
      for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0);
      check("addi_x3_instret", {16'h0, instret}, 32'd3);

      // bne taken and not taken; lbu with a 4-cycle load wait.
      run_instr(1, 0, 0, 1'b0);
      run_instr(1, 0, 0, 1'b1);
      run_instr(2, 0, 4, 1'b0);
      idle_a(3);

      // Randomized instruction stream with wait states and idle gaps.
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
         run_instr(kind, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_a(int'($urandom_range(1, 3)));
      end

      // Wait counter at its limit: ack on the last allowed cycle still wins.
      run_instr(0, MW_A, 0, 1'b0);
      run_instr(2, 0, MW_A, 1'b0);

      // Unsupported instruction halts; controls frozen afterwards.
      run_instr(3, 0, 0, 1'b0);
      run_instr(0, 0, 0, 1'b0);

      // Fetch timeout on A: MAX_WAIT+1 request cycles without an ack.
      en = 1'b1;
      imem_ack = 1'b0;
      for (int i = 0; i <= MW_A; i++)
         tick("a_to_fetch", vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      tick("a_to_halt", vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 2'b10));
      reset_a();

      // Asynchronous reset in the middle of a load.
      run_instr(0, 0, 0, 1'b0);
      en = 1'b1;
      imem_ack = 1'b1;
      tick("pre_fetch", vec(1, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      instr = gen(2);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      tick("pre_decode", 16'h0);
      #2;
      check("mem_dmem_req_before_rst", {31'h0, dmem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      model_ret = 0;
      check("async_dmem_req", {31'h0, dmem_req}, 32'd0);
      check("async_instret", {16'h0, instret}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = 1'b1;
      imem_ack = 1'b0;
      tick("post_rst_fetch", vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      idle_a(2);

      // Instance B: timeout after 4 request cycles.
      b_en = 1'b1;
      b_imem_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         b_tick("b_to_fetch", vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      b_tick("b_to_halt", vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 2'b10));
      b_imem_ack = 1'b1;
      b_tick("b_halt_sticky", vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 2'b10));
      reset_b();

      // Instance B: ack in the 4th request cycle proceeds without error.
      b_en = 1'b1;
      b_imem_ack = 1'b0;
      for (int i = 0; i < 3; i++)
         b_tick("b_wait", vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      b_imem_ack = 1'b1;
      b_tick("b_ack4", vec(1, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 2'b00));
      b_instr = gen(0);
      b_imem_ack = 1'b0;
      b_tick("b_decode_ok", 16'h0);
      b_tick("b_ex_i_ok", vec(0, 0, 1, 0, 1, 0, 3'b000, 1, 2'b00, 0, 0, 2'b00));
      b_ret++;

      // Instance B: 2-bit counter wraps after the 4th retire.
      for (int i = 0; i < 3; i++) b_run_addi();
      check("b_instret_wrap", {30'h0, b_instret}, 32'd0);
      b_en = 1'b0;
      b_tick("b_idle", 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
